// File: rtl/hazard_pkg.sv
// Shared register-file and scoreboard definitions for the decode-stage hazard logic.
package hazard_pkg;

    localparam int unsigned NUM_REGS        = 32;
    localparam int unsigned MAX_OUT_DEFAULT = 4;
    localparam int unsigned CNT_W           = 4;

    typedef logic [4:0]       reg_idx_t;
    typedef logic [CNT_W-1:0] out_cnt_t;

    typedef struct packed {
        logic raw;
        logic waw;
        logic full;
    } hazard_t;

endpackage

// File: rtl/sb_busy_table.sv
// Busy bit per architectural register plus count of long-latency writes in flight.
module sb_busy_table
    import hazard_pkg::*;
(
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                setEn,
    input  reg_idx_t            setIdx,
    input  logic                clrEn,
    input  reg_idx_t            clrIdx,
    output logic [NUM_REGS-1:0] busyVec,
    output out_cnt_t            outCnt
);

    logic [NUM_REGS-1:0] busyQ;
    logic [NUM_REGS-1:0] busyNext;
    out_cnt_t            cntQ;
    out_cnt_t            cntNext;

    always_comb begin
        busyNext = busyQ;
        if (clrEn) busyNext[clrIdx] = 1'b0;
        // Set applied after clear so a same-register set/clear leaves the bit busy.
        if (setEn) busyNext[setIdx] = 1'b1;
        busyNext[0] = 1'b0;

        cntNext = cntQ;
        if (setEn && !clrEn) begin
            cntNext = cntQ + out_cnt_t'(1);
        end else if (clrEn && !setEn) begin
            cntNext = cntQ - out_cnt_t'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busyQ <= '0;
            cntQ  <= '0;
        end else begin
            busyQ <= busyNext;
            cntQ  <= cntNext;
        end
    end

    assign busyVec = busyQ;
    assign outCnt  = cntQ;

endmodule

// File: rtl/reg_scoreboard.sv
// In-order pipeline register scoreboard: tracks long-latency destinations and
// raises stall/flush controls for RAW, WAW and in-flight-limit hazards.
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned MAX_OUT = MAX_OUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IssueValidD,
    input  logic        IssueLongD,
    input  logic [4:0]  IssueRdD,
    input  logic [4:0]  RS1D,
    input  logic [4:0]  RS2D,
    input  logic        UseRS1D,
    input  logic        UseRS2D,
    input  logic        WbValidW,
    input  logic        WbLongW,
    input  logic [4:0]  WbRdW,
    input  logic        PCSrcE,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic [31:0] BusyVec,
    output logic [3:0]  OutCnt,
    output logic        SbError
);

    logic     wbLong;
    logic     wbError;
    logic     wbClear;
    logic     issueAccept;
    logic     sbErrQ;
    hazard_t  haz;
    out_cnt_t maxOut;

    assign maxOut = out_cnt_t'(MAX_OUT);

    // A bad writeback (nothing in flight, or target not busy) must leave the table untouched.
    always_comb begin
        wbLong  = WbValidW & WbLongW;
        wbError = wbLong & ((OutCnt == '0) | ((WbRdW != '0) & ~BusyVec[WbRdW]));
        wbClear = wbLong & ~wbError;
    end

    always_comb begin
        haz.raw  = (UseRS1D & (RS1D != '0) & BusyVec[RS1D] & ~(wbLong & (WbRdW == RS1D)))
                 | (UseRS2D & (RS2D != '0) & BusyVec[RS2D] & ~(wbLong & (WbRdW == RS2D)));
        haz.waw  = IssueValidD & (IssueRdD != '0) & BusyVec[IssueRdD]
                 & ~(wbClear & (WbRdW == IssueRdD));
        // Only a writeback that really frees a slot can make room for a new long op.
        haz.full = IssueValidD & IssueLongD & (OutCnt == maxOut) & ~wbClear;
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (RST_N) begin
            if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (|haz) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign issueAccept = IssueValidD & IssueLongD & (IssueRdD != '0) & ~StallD & ~PCSrcE;

    sb_busy_table uBusyTable (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .setEn   (issueAccept),
        .setIdx  (IssueRdD),
        .clrEn   (wbClear),
        .clrIdx  (WbRdW),
        .busyVec (BusyVec),
        .outCnt  (OutCnt)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sbErrQ <= 1'b0;
        end else if (wbError) begin
            sbErrQ <= 1'b1;
        end
    end

    assign SbError = sbErrQ;

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter: MAX_OUT, default 4, maximum long-latency writes in flight (range 1-15).
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST_N  in  1  asynchronous, active-low reset.
REQ-004 IssueValidD  in  1  decode-stage instruction valid and attempting to advance to E.
REQ-005 IssueLongD  in  1  decode-stage instruction is long-latency (load, mul/div) and writes rd.
REQ-006 IssueRdD  in  5  destination register of the decode-stage instruction.
REQ-007 RS1D, RS2D  in  5 each  decode-stage source registers.
REQ-008 UseRS1D, UseRS2D  in  1 each  the corresponding source is actually read.
REQ-009 WbValidW, WbLongW  in  1 each  writeback valid; writeback belongs to a long-latency op.
REQ-010 WbRdW  in  5  writeback destination register.
REQ-011 PCSrcE  in  1  taken branch/jump resolved in E.
REQ-012 StallF, StallD, FlushD, FlushE  out  1 each  pipeline control.
REQ-013 BusyVec  out  32  current busy bit per register; bit 0 always 0.
REQ-014 OutCnt  out  4  long ops in flight.
REQ-015 SbError  out  1  sticky protocol-error flag.

Function
REQ-016 Busy table: one bit per register x1-x31; x0 never busy.
REQ-017 Long issue accepted when IssueValidD & IssueLongD & IssueRdD!=0 & !StallD & !PCSrcE; it sets busy[IssueRdD] and increments OutCnt at the next edge.
REQ-018 Long writeback (WbValidW & WbLongW) clears busy[WbRdW] and decrements OutCnt at the next edge.
REQ-019 Same-register set and clear in one cycle: set wins, so the bit stays 1.
REQ-020 Accepted issue plus long writeback in one cycle: OutCnt unchanged.
REQ-021 RAW hazard when, for either source, UseRSxD & RSxD!=0 & busy[RSxD] & !(WbValidW & WbLongW & WbRdW==RSxD); a same-cycle writeback bypasses the hazard.
REQ-022 WAW hazard when IssueValidD & IssueRdD!=0 & busy[IssueRdD] is not cleared in the same cycle.
REQ-023 Full hazard when IssueValidD & IssueLongD & OutCnt==MAX_OUT & no long writeback in the same cycle.
REQ-024 Any hazard with PCSrcE=0 gives StallF=StallD=FlushE=1 and FlushD=0, combinationally in the same cycle; the issue is not accepted.
REQ-025 PCSrcE=1 gives FlushD=FlushE=1 and StallF=StallD=0 (flush beats stall); no issue is accepted that cycle.
REQ-026 A flush does not clear busy bits or OutCnt, because in-flight long ops are older and still write back.
REQ-027 Long writeback with OutCnt==0 or busy[WbRdW]==0 (WbRdW!=0): SbError set sticky; OutCnt holds at 0 (no underflow) and busy state is unchanged.
REQ-028 OutCnt never exceeds MAX_OUT; an increment at MAX_OUT cannot occur because of REQ-023.
REQ-029 Non-long writebacks (WbLongW=0) do not affect the scoreboard.
REQ-030 No hazard and no PCSrcE: all four control outputs are 0.

Reset
REQ-031 RST_N low asynchronously clears the busy table, OutCnt and SbError; while RST_N is low, BusyVec=0, OutCnt=0, SbError=0, and StallF/StallD/FlushD/FlushE=0.
REQ-032 Reset asserted mid-operation drops all in-flight tracking; the first edge after release behaves as an empty scoreboard.

Structure
REQ-033 A shared package hazard_pkg holds NUM_REGS=32, the reg_idx_t 5-bit typedef and the MAX_OUT default.
REQ-034 Busy table and OutCnt form one sub-module, sb_busy_table (set/clear ports, vector out); hazard and flush logic stays in reg_scoreboard.

Verification
REQ-035 Long issue to x5, then next cycle RS1D=5 with UseRS1D=1 -> StallF/StallD/FlushE=1 until the cycle WbRdW=5 with WbLongW=1, which has no stall (bypass); busy[5]=0 after that edge.
REQ-036 Four long issues to x1-x4 with no writeback, then a fifth long issue -> OutCnt=4 and the fifth stalls; on the same cycle as WbRdW=1 long, the fifth is accepted and OutCnt stays 4.
REQ-037 Hazard on RS2D=7 together with PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0; busy[7] is still 1 afterwards.
REQ-038 Issue to x9 with writeback to x9 in the same cycle -> busy[9]=1 and OutCnt unchanged.
REQ-039 Long writeback with OutCnt=0 -> SbError=1 and stays 1; OutCnt=0.
REQ-040 Three ops in flight, then RST_N pulsed low between edges -> BusyVec=0 and OutCnt=0 immediately; a following RS1D to a previously busy register causes no stall.
